keypad_scan_fifo: RTL

//  Parametrised matrix-keypad scanner for the PicoBlaze I/O subsystem: drives one-hot active-low columns,

---
 rtl/keypad_scan_fifo.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_fifo.sv
// rtl/keypad_scan_fifo.sv - matrix keypad scanner with debounce, key-code encoder and FIFO
//
// Purpose: drives one-hot active-low columns, synchronises and debounces the
// active-low rows, encodes each accepted press as c*ROWS + r + 1 and queues the
// code in a first-word fall-through FIFO read by the CPU input-port mux.
//
// Ports:
//   clk          system clock
//   pb_reset     asynchronous active-high reset
//   row          keypad rows, asynchronous, active-low
//   col          column drive, active-low, at most one bit low
//   key_data     FIFO head code, 0 when empty
//   key_present  FIFO not empty
//   key_read     single-cycle pop strobe
//   fifo_count   FIFO occupancy
//   overflow     sticky: a code was dropped because the FIFO was full
//   overflow_clr clears overflow
module keypad_scan_fifo #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 2000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          pb_reset,
  input  logic [ROWS-1:0]               row,
  output logic [COLS-1:0]               col,
  output logic [7:0]                    key_data,
  output logic                          key_present,
  input  logic                          key_read,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [CW-1:0]   c_q, c_d, c_inc;
  logic [RW-1:0]   r_lat_q, r_lat_d, low_idx;
  logic [ROWS-1:0] pat_q, pat_d;
  logic [ROWS-1:0] row_meta, rs;
  logic            all_high;
  logic            push;
  logic [7:0]      push_code;

  // Two-flop synchroniser; idles at all-high so reset never looks like a press.
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      row_meta <= '1;
      rs       <= '1;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  assign all_high = &rs;
  assign c_inc    = (c_q == CW'(COLS - 1)) ? '0 : c_q + 1'b1;

  // Lowest-index low row wins when several rows in the held column are low.
  always_comb begin
    low_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs[i]) low_idx = RW'(i);
    end
  end

  assign push_code = 8'(8'(c_q) * 8'(ROWS) + 8'(r_lat_q) + 8'd1);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    dcnt_d  = dcnt_q;
    c_d     = c_q;
    r_lat_d = r_lat_q;
    pat_d   = pat_q;
    push    = 1'b0;
    case (state_q)
      SCAN: begin
        if (slot_q == SW'(SCAN_DIV - 1)) begin
          slot_d = '0;
          if (!all_high) begin
            pat_d   = rs;
            r_lat_d = low_idx;
            dcnt_d  = '0;
            state_d = DEBOUNCE;
          end else begin
            c_d = c_inc;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs != pat_q) begin
          state_d = SCAN;
          c_d     = c_inc;
          slot_d  = '0;
        end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          push    = 1'b1;
          dcnt_d  = '0;
          state_d = HOLD;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      HOLD: begin
        // Any low row (including a second key) restarts the release timer.
        if (!all_high) begin
          dcnt_d = '0;
        end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          dcnt_d  = '0;
          state_d = SCAN;
          c_d     = c_inc;
          slot_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SCAN;
        slot_d  = '0;
        dcnt_d  = '0;
        c_d     = '0;
      end
    endcase
  end

  // col is loaded from the next column index so it stays aligned with c_q,
  // yet reads all-high while reset is asserted.
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      state_q <= SCAN;
      slot_q  <= '0;
      dcnt_q  <= '0;
      c_q     <= '0;
      r_lat_q <= '0;
      pat_q   <= '1;
      col     <= '1;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      dcnt_q  <= dcnt_d;
      c_q     <= c_d;
      r_lat_q <= r_lat_d;
      pat_q   <= pat_d;
      col     <= ~(COLS'(1) << c_d);
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_pop, do_push;

  assign full    = (fifo_count == CNTW'(FIFO_DEPTH));
  assign do_pop  = key_read && key_present;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign key_present = (fifo_count != '0);
  assign key_data    = key_present ? mem[rd_ptr] : 8'h00;

endmodule
